// File: rtl/elastic_pipe_pkg.sv
// elastic_pipe_pkg
//   Shared types and helpers for the elastic valid/ready pipeline.
//   - count_width(depth): bits needed to hold an occupancy of 0..depth.
//   - xfer_e: which handshakes complete on a given edge, used by the
//     occupancy counter.
package elastic_pipe_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    IN_ONLY  = 2'd1,
    OUT_ONLY = 2'd2,
    BOTH     = 2'd3
  } xfer_e;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// elastic_stage
//   One register stage of the elastic pipeline: a valid flag, a data word
//   and the stage's ready term.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   flush_i     synchronous clear of the valid flag (data is kept)
//   up_valid    valid from the upstream side (input port or previous stage)
//   up_data     data from the upstream side
//   down_rdy    ready of the downstream side (next stage or ready_i)
//   valid_r     registered valid of this stage
//   data_r      registered data of this stage
//   rdy_s       stage can take a new beat: empty, or its beat moves on
module elastic_stage
  import elastic_pipe_pkg::*;
#(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_rdy,
  output logic             valid_r,
  output logic [WIDTH-1:0] data_r,
  output logic             rdy_s
);

  assign rdy_s = !valid_r || down_rdy;

  // Stage register: load from upstream when ready; data only moves with a valid beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      data_r  <= RESET_VALUE;
    end else if (flush_i) begin
      valid_r <= 1'b0;
    end else if (rdy_s) begin
      valid_r <= up_valid;
      if (up_valid) begin
        data_r <= up_data;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// elastic_pipe
//   DEPTH-stage, WIDTH-bit valid/ready pipeline with bubble collapsing,
//   synchronous flush and a registered occupancy count.
// Ports:
//   clk      single clock, rising edge
//   rst      asynchronous active-low reset
//   flush_i  synchronous clear of every stage's valid flag
//   valid_i  upstream data valid
//   ready_o  pipeline can accept data_i this cycle
//   data_i   upstream data
//   valid_o  last stage holds valid data
//   ready_i  downstream accepts data_o this cycle
//   data_o   data of the last stage
//   count_o  number of valid stages
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CW          = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  // Each stage owns its own ready wire; chaining them through separate
  // per-block signals keeps the ready_i -> ready_o path a plain chain.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_valid_s;
    logic [WIDTH-1:0] up_data_s;
    logic             down_rdy_s;
    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic             rdy_s;

    if (k == 0) begin : g_head
      assign up_valid_s = valid_i;
      assign up_data_s  = data_i;
    end else begin : g_link
      assign up_valid_s = g_stage[k-1].valid_r;
      assign up_data_s  = g_stage[k-1].data_r;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign down_rdy_s = ready_i;
    end else begin : g_mid
      assign down_rdy_s = g_stage[k+1].rdy_s;
    end

    elastic_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (flush_i),
      .up_valid (up_valid_s),
      .up_data  (up_data_s),
      .down_rdy (down_rdy_s),
      .valid_r  (valid_r),
      .data_r   (data_r),
      .rdy_s    (rdy_s)
    );
  end

  logic          in_xfer_s;
  logic          out_xfer_s;
  xfer_e         xfer_s;
  logic [CW-1:0] count_r;

  // Flush blocks input so nothing is accepted into a pipe being cleared.
  assign ready_o    = g_stage[0].rdy_s && !flush_i;
  assign valid_o    = g_stage[DEPTH-1].valid_r;
  assign data_o     = g_stage[DEPTH-1].data_r;
  assign in_xfer_s  = valid_i && ready_o;
  assign out_xfer_s = valid_o && ready_i;
  assign count_o    = count_r;

  // Classify this cycle's handshakes for the occupancy counter.
  always_comb begin
    xfer_s = NONE;
    case ({in_xfer_s, out_xfer_s})
      2'b10:   xfer_s = IN_ONLY;
      2'b01:   xfer_s = OUT_ONLY;
      2'b11:   xfer_s = BOTH;
      default: xfer_s = NONE;
    endcase
  end

  // Occupancy counter; tracks the number of valid stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {CW{1'b0}};
    end else if (flush_i) begin
      count_r <= {CW{1'b0}};
    end else begin
      case (xfer_s)
        IN_ONLY:  count_r <= count_r + CNT_ONE;
        OUT_ONLY: count_r <= count_r - CNT_ONE;
        default:  count_r <= count_r;
      endcase
    end
  end

endmodule
